// File: rtl/ssd1306_receiver.sv
// SSD1306-style SPI receiver: decodes addressing commands and emits framebuffer writes.
// Define SSD1306_RECEIVER_CMD_LOG_EN to report every command-class byte on cmd_valid/cmd_byte.
module ssd1306_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_din,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_rst,
  output logic       fb_we,
  output logic [2:0] fb_page,
  output logic [6:0] fb_col,
  output logic [7:0] fb_data,
  output logic       display_on,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte
);

  typedef enum logic [2:0] {
    IDLE, COL_START, COL_END, PAGE_START, PAGE_END, SKIP_ARG
  } state_e;

  // Synchroniser bit order {rst, cs, dc, clk, din}; cs and rst idle high.
  localparam logic [4:0] SYNC_RST = 5'b11000;

  logic [4:0] sync_q [SYNC_STAGES];
  logic       din_s, sclk_s, dc_s, cs_s, srst_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      sync_q[0] <= {spi_rst, spi_cs, spi_dc, spi_clk, spi_din};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {srst_s, cs_s, dc_s, sclk_s, din_s} = sync_q[SYNC_STAGES-1];

  logic       sclk_prev_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q;
  logic       dc_q;
  logic       sclk_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      dc_q        <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      byte_done_q <= 1'b0;
      if (!srst_s || cs_s) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise) begin
        shift_q   <= {shift_q[6:0], din_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done_q <= 1'b1;
          dc_q        <= dc_s;
        end
      end
    end
  end

  state_e     state_q, state_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d;
  logic [2:0] page_start_q, page_start_d, page_end_q, page_end_d, page_ptr_q, page_ptr_d;
  logic       display_on_q, display_on_d, fb_we_q, fb_we_d;
  logic [2:0] fb_page_q, fb_page_d;
  logic [6:0] fb_col_q, fb_col_d;
  logic [7:0] fb_data_q, fb_data_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    state_d      = state_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    col_ptr_d    = col_ptr_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    page_ptr_d   = page_ptr_q;
    display_on_d = display_on_q;
    fb_we_d      = 1'b0;
    fb_page_d    = fb_page_q;
    fb_col_d     = fb_col_q;
    fb_data_d    = fb_data_q;

    if (!srst_s) begin
      state_d      = IDLE;
      col_start_d  = 7'd0;
      col_end_d    = 7'd127;
      col_ptr_d    = 7'd0;
      page_start_d = 3'd0;
      page_end_d   = 3'd7;
      page_ptr_d   = 3'd0;
      display_on_d = 1'b0;
    end else if (byte_done_q && dc_q) begin
      fb_we_d   = 1'b1;
      fb_page_d = page_ptr_q;
      fb_col_d  = col_ptr_q;
      fb_data_d = shift_q;
      // Horizontal addressing: wrap the column window, then step the page window.
      if (col_ptr_q == col_end_q) begin
        col_ptr_d  = col_start_q;
        page_ptr_d = (page_ptr_q == page_end_q) ? page_start_q : page_ptr_q + 3'd1;
      end else begin
        col_ptr_d = col_ptr_q + 7'd1;
      end
    end else if (byte_done_q) begin
      unique case (state_q)
        IDLE: begin
          case (shift_q)
            8'h21: state_d = COL_START;
            8'h22: state_d = PAGE_START;
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: state_d = SKIP_ARG;
            8'hAE: display_on_d = 1'b0;
            8'hAF: display_on_d = 1'b1;
            default: state_d = IDLE;
          endcase
        end
        COL_START: begin
          col_start_d = shift_q[6:0];
          state_d     = COL_END;
        end
        COL_END: begin
          col_end_d = shift_q[6:0];
          col_ptr_d = col_start_q;
          state_d   = IDLE;
        end
        PAGE_START: begin
          page_start_d = shift_q[2:0];
          state_d      = PAGE_END;
        end
        PAGE_END: begin
          page_end_d = shift_q[2:0];
          page_ptr_d = page_start_q;
          state_d    = IDLE;
        end
        SKIP_ARG: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'd127;
      col_ptr_q    <= 7'd0;
      page_start_q <= 3'd0;
      page_end_q   <= 3'd7;
      page_ptr_q   <= 3'd0;
      display_on_q <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_page_q    <= 3'd0;
      fb_col_q     <= 7'd0;
      fb_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      col_ptr_q    <= col_ptr_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      page_ptr_q   <= page_ptr_d;
      display_on_q <= display_on_d;
      fb_we_q      <= fb_we_d;
      fb_page_q    <= fb_page_d;
      fb_col_q     <= fb_col_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_page    = fb_page_q;
  assign fb_col     = fb_col_q;
  assign fb_data    = fb_data_q;
  assign display_on = display_on_q;

`ifdef SSD1306_RECEIVER_CMD_LOG_EN
  logic       cmd_valid_q;
  logic [7:0] cmd_byte_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'd0;
    end else begin
      cmd_valid_q <= srst_s && byte_done_q && !dc_q;
      if (srst_s && byte_done_q && !dc_q) cmd_byte_q <= shift_q;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
`else
  assign cmd_valid = 1'b0;
  assign cmd_byte  = 8'd0;
`endif

endmodule

// File: tb/tb_ssd1306_receiver.sv
// Directed bench for ssd1306_receiver: SPI byte transfers with hand-computed framebuffer writes.
module tb_ssd1306_receiver;

  localparam int SYNC = 2;
  localparam int HP   = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_din = 1'b0, spi_clk = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0, spi_rst = 1'b1;
  logic       fb_we, display_on, cmd_valid;
  logic [2:0] fb_page;
  logic [6:0] fb_col;
  logic [7:0] fb_data, cmd_byte;

  ssd1306_receiver #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .spi_din(spi_din), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .spi_rst(spi_rst), .fb_we(fb_we), .fb_page(fb_page), .fb_col(fb_col),
    .fb_data(fb_data), .display_on(display_on), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          lat;
  logic [31:0] wq[$];
  logic [31:0] expq[$];
  logic [7:0]  cq[$];
  logic [7:0]  init_seq [25] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1,
    8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

  // Record strobes mid-cycle, away from the DUT's active edge.
  always @(negedge clk) begin
    if (fb_we === 1'b1) wq.push_back({14'b0, fb_page, fb_col, fb_data});
    if (cmd_valid === 1'b1) cq.push_back(cmd_byte);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input int p, input int c, input int d);
    return {14'b0, p[2:0], c[6:0], d[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  // Clock out the top nbits of b with cs held low; lat records cycles from the last rising edge to fb_we.
  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dc);
    spi_dc = dc;
    spi_cs = 1'b0;
    wait_n(HP);
    lat = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_din = b[i];
      spi_clk = 1'b0;
      wait_n(HP);
      spi_clk = 1'b1;
      for (int k = 1; k <= HP; k++) begin
        tick();
        if (fb_we === 1'b1 && lat == 0) lat = k;
      end
    end
    spi_clk = 1'b0;
    wait_n(HP);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    send_bits(b, 8, dc);
    spi_cs = 1'b1;
    wait_n(HP);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, wq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wq.size(); i++)
      check($sformatf("%s_w%0d", tag, i), wq[i], expq[i]);
    wq.delete();
  endtask

  initial begin
    wait_n(3);
    check("rst_fb_we", fb_we, 1'b0);
    check("rst_fb_addr", {fb_page, fb_col, fb_data}, 18'd0);
    check("rst_display_on", display_on, 1'b0);
    check("rst_cmd", {cmd_valid, cmd_byte}, 9'd0);
    rst_n = 1'b1;
    wait_n(5);

    // Partial byte dropped by cs, then a full data byte at the reset pointers.
    send_bits(8'hFF, 5, 1'b1);
    spi_cs = 1'b1;
    wait_n(HP);
    send_byte(1'b1, 8'h3C);
    check("latency", lat, SYNC + 2);
    expq = '{wr(0, 0, 8'h3C)};
    check_writes("partial");
    check("hold_data", fb_data, 8'h3C);

    // Column window 5..7, page pointer still 0.
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h05); send_byte(1'b0, 8'h07);
    send_byte(1'b1, 8'hA1); send_byte(1'b1, 8'hA2); send_byte(1'b1, 8'hA3); send_byte(1'b1, 8'hA4);
    expq = '{wr(0, 5, 8'hA1), wr(0, 6, 8'hA2), wr(0, 7, 8'hA3), wr(1, 5, 8'hA4)};
    check_writes("colwin");

    // Single-column window at 127, pages 6..7 wrap.
    send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h06); send_byte(1'b0, 8'h07);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h7F); send_byte(1'b0, 8'h7F);
    send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22); send_byte(1'b1, 8'h33);
    expq = '{wr(6, 127, 8'h11), wr(7, 127, 8'h22), wr(6, 127, 8'h33)};
    check_writes("pagewrap");

    send_byte(1'b0, 8'hAF);
    check("disp_on", display_on, 1'b1);
    send_byte(1'b0, 8'h81); send_byte(1'b0, 8'hAE);
    check("disp_arg_consumed", display_on, 1'b1);
    send_byte(1'b0, 8'hAE);
    check("disp_off", display_on, 1'b0);

    // Display reset mid-argument restores defaults and IDLE.
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h10);
    spi_rst = 1'b0;
    wait_n(10);
    spi_rst = 1'b1;
    wait_n(10);
    send_byte(1'b1, 8'h55);
    expq = '{wr(0, 0, 8'h55)};
    check_writes("spirst");
    send_byte(1'b0, 8'hAF);
    check("spirst_idle", display_on, 1'b1);

    // Async reset mid-byte and mid-argument, then a new byte without raising cs.
    send_byte(1'b0, 8'h22);
    send_bits(8'hF0, 4, 1'b0);
    rst_n = 1'b0;
    wait_n(3);
    check("rstn_display", display_on, 1'b0);
    check("rstn_fb_data", fb_data, 8'h00);
    rst_n = 1'b1;
    wait_n(5);
    send_bits(8'hAF, 8, 1'b0);
    spi_cs = 1'b1;
    wait_n(HP);
    check("rstn_idle", display_on, 1'b1);

    // Init sequence: commands only, optionally logged.
    cq.delete();
    wq.delete();
    for (int i = 0; i < 25; i++) send_byte(1'b0, init_seq[i]);
    check("init_no_writes", wq.size(), 0);
    check("init_display", display_on, 1'b1);
`ifdef SSD1306_RECEIVER_CMD_LOG_EN
    check("init_cmd_count", cq.size(), 25);
    for (int i = 0; i < 25 && i < cq.size(); i++)
      check($sformatf("init_cmd%0d", i), cq[i], init_seq[i]);
`else
    check("init_cmd_count", cq.size(), 0);
    check("init_cmd_idle", {cmd_valid, cmd_byte}, 9'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd1306_receiver.md
SSD1306_RECEIVER -- requirements
Module: ssd1306_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flop synchroniser stages on each SPI input.
REQ-002 SHALL have port clk  in  1: system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port spi_din  in  1: serial data, MSB first.
REQ-005 SHALL have port spi_clk  in  1: SPI clock; data sampled on its rising edge.
REQ-006 SHALL have port spi_cs  in  1: chip select, active low.
REQ-007 SHALL have port spi_dc  in  1: 0 = command byte, 1 = data byte.
REQ-008 SHALL have port spi_rst  in  1: display reset, active low.
REQ-009 SHALL have port fb_we  out  1: framebuffer write strobe, one cycle wide.
REQ-010 SHALL have port fb_page  out  3: write page address.
REQ-011 SHALL have port fb_col  out  7: write column address.
REQ-012 SHALL have port fb_data  out  8: write data byte; bit 0 is the top row of the page.
REQ-013 SHALL have port display_on  out  1: 1 after command 0xAF, 0 after command 0xAE.
REQ-014 SHALL have port cmd_valid  out  1: one-cycle pulse per command-class byte.
REQ-015 SHALL have port cmd_byte  out  8: value of the command-class byte (see REQ-033).

Function
REQ-016 SHALL pass spi_din, spi_clk, spi_cs, spi_dc and spi_rst through SYNC_STAGES flip-flops before any use.
REQ-017 SHALL detect a rising edge as synchronised spi_clk 0 then 1, and SHALL count it only if synchronised spi_cs is 0 in the same cycle.
REQ-018 SHALL, on each counted edge, shift synchronised spi_din into an 8-bit shift register MSB first and increment a 3-bit bit counter.
REQ-019 SHALL complete a byte on the 8th counted edge and take dc from synchronised spi_dc in that cycle.
REQ-020 SHALL clear the bit counter, discarding any partial byte, whenever synchronised spi_cs is 1.
REQ-021 SHALL decode command bytes in FSM states IDLE, COL_START, COL_END, PAGE_START, PAGE_END, SKIP_ARG.
REQ-022 SHALL, in IDLE, handle command bytes as follows:
- 0x21 -> COL_START
- 0x22 -> PAGE_START
- 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB -> SKIP_ARG
- 0xAE / 0xAF -> clear / set display_on
- any other byte -> ignored, stay in IDLE
REQ-023 SHALL treat the next command byte received in each argument state as follows:
- COL_START: col_start = byte[6:0], go to COL_END
- COL_END: col_end = byte[6:0], col_ptr = col_start, go to IDLE
- PAGE_START: page_start = byte[2:0], go to PAGE_END
- PAGE_END: page_end = byte[2:0], page_ptr = page_start, go to IDLE
- SKIP_ARG: discard byte, go to IDLE
REQ-024 SHALL leave the FSM state unchanged when a data byte arrives.
REQ-025 SHALL, for each data byte, drive fb_page = page_ptr, fb_col = col_ptr and fb_data = byte, and pulse fb_we in the cycle after byte completion.
REQ-026 SHALL advance the pointers after each data byte using horizontal addressing:
- col_ptr != col_end: col_ptr + 1, modulo 128
- col_ptr == col_end: col_ptr = col_start, then page_ptr steps the same way (modulo 8, wrapping from page_end to page_start)
REQ-027 SHALL keep fb_page, fb_col and fb_data stable while fb_we is 0.
REQ-028 SHALL give a latency of exactly SYNC_STAGES+2 clk cycles from the 8th spi_clk rising edge at the pin to fb_we.
REQ-029 SHALL operate correctly when spi_clk high and low phases are each at least SYNC_STAGES+1 clk cycles; behaviour with faster spi_clk is unspecified.
REQ-030 SHALL, while synchronised spi_rst is 0:
- clear the bit counter
- set the FSM to IDLE
- set col_start=0, col_end=127, page_start=0, page_end=7, col_ptr=0, page_ptr=0
- clear display_on and suppress fb_we and cmd_valid

Reset
REQ-031 SHALL, while rst_n is 0, asynchronously force:
- all synchroniser flip-flops to spi_cs=1, spi_rst=1 and all other inputs 0
- the REQ-030 defaults
- fb_we=0, fb_page=0, fb_col=0, fb_data=0, display_on=0, cmd_valid=0, cmd_byte=0
REQ-032 SHALL drop any partial byte or pending argument state when rst_n is asserted mid-transfer.

Configuration
REQ-033 SHALL, with macro SSD1306_RECEIVER_CMD_LOG_EN defined, pulse cmd_valid with cmd_byte = byte in the cycle after every command-class byte completes, argument bytes included.
REQ-034 SHALL, with SSD1306_RECEIVER_CMD_LOG_EN undefined, tie cmd_valid and cmd_byte to 0 and synthesise no logging logic.

Verification
REQ-035 SHALL cover this scenario: SPI half-period 11 clk, command 0x21, 0x05, 0x07, then data 0xA1, 0xA2, 0xA3, 0xA4 -> fb_we writes at (page 0, col 5), (0, 6), (0, 7), (1, 5) with those data values.
REQ-036 SHALL cover this scenario: command 0x22, 0x06, 0x07 and 0x21, 0x7F, 0x7F, then 3 data bytes -> writes at (6, 127), (7, 127), (6, 127).
REQ-037 SHALL cover this scenario: 5 bits clocked, spi_cs raised, then a full data byte 0x3C -> a single write of 0x3C at (0, 0).
REQ-038 SHALL cover this scenario: command 0xAF -> display_on=1; command 0x81, 0xAE -> display_on stays 1 (0xAE consumed as the argument); command 0xAE -> display_on=0.
REQ-039 SHALL cover this scenario: spi_rst pulsed low after command 0x21, 0x10 -> the next data byte is written at (0, 0) and the FSM is back in IDLE.
REQ-040 SHALL cover this scenario: with SSD1306_RECEIVER_CMD_LOG_EN defined, the 25-byte init sequence -> 25 cmd_valid pulses with matching bytes and no fb_we; with the macro undefined -> cmd_valid stays 0.
